leaf_multi_arb: RTL and testbench

LEAF_MULTI_ARB -- requirements
Module: leaf_multi_arb

---
 rtl/leaf_pkg.sv | 18 +
 rtl/leaf_multi_arb_if.sv | 30 +++
 rtl/leaf_pkt_fifo.sv | 56 +++++
 rtl/leaf_multi_arb.sv | 137 +++++++++++++
 tb/tb_leaf_multi_arb.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf/BFT multi-channel arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default packet width, valid/dest field positions, egress FSM states.
package leaf_pkg;

  localparam int PKT_W   = 49;
  localparam int VLD_BIT = PKT_W - 1;
  localparam int DEST_HI = PKT_W - 2;
  localparam int DEST_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/leaf_multi_arb_if.sv
// Bundle of BFT-side and leaf-side packet buses around leaf_multi_arb.
// Latency: n/a (wires only).
// Backpressure: resend from the BFT side holds the egress packet.
// master: drives BFT ingress, resend, ap_start and leaf egress; slave: the arbiter.
interface leaf_multi_arb_if #(
  parameter int NUM_LEAF = 2,
  parameter int PKT_W    = leaf_pkg::PKT_W
);
  logic [PKT_W-1:0]          din_leaf_bft2interface;
  logic [PKT_W-1:0]          dout_leaf_interface2bft;
  logic                      resend;
  logic                      ap_start;
  logic [NUM_LEAF*PKT_W-1:0] din_leaf_interface2bft;
  logic [NUM_LEAF*PKT_W-1:0] dout_leaf_bft2interface;
  logic [NUM_LEAF-1:0]       leaf_ap_start;
  logic [NUM_LEAF-1:0]       overflow;
  logic [15:0]               drop_cnt;

  modport master (
    output din_leaf_bft2interface, resend, ap_start, din_leaf_interface2bft,
    input  dout_leaf_interface2bft, dout_leaf_bft2interface, leaf_ap_start,
           overflow, drop_cnt
  );

  modport slave (
    input  din_leaf_bft2interface, resend, ap_start, din_leaf_interface2bft,
    output dout_leaf_interface2bft, dout_leaf_bft2interface, leaf_ap_start,
           overflow, drop_cnt
  );
endinterface

// File: rtl/leaf_pkt_fifo.sv
// Per-leaf egress packet FIFO with first-word-fall-through head.
// Latency: a push is visible at head_dat/empty one cycle later.
// Backpressure: none upstream; a push while full (and not popped) is dropped and flagged on drop.
// Ports: clk/reset, push/push_dat in, pop in, head_dat/empty/full/drop out.
module leaf_pkt_fifo #(
  parameter int PKT_W = 49,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [PKT_W-1:0] push_dat,
  input  logic             pop,
  output logic [PKT_W-1:0] head_dat,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A slot freed by a same-cycle pop lets a push into a full FIFO land.
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/leaf_multi_arb.sv
// Shares one BFT link among NUM_LEAF leaves: routes ingress by dest, round-robins egress.
// Latency: ingress 1 cycle; egress >= 2 cycles from leaf push to dout.
// Backpressure: resend with a valid dout holds it (HOLD) with no pop; leaves see only overflow.
// Ports: clk, reset (async, active-high), bus (slave modport of leaf_multi_arb_if).
module leaf_multi_arb
  import leaf_pkg::*;
#(
  parameter int NUM_LEAF   = 2,
  parameter int PKT_W      = leaf_pkg::PKT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  leaf_multi_arb_if.slave   bus
);
  localparam int IDX_W = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1;

  // ---------------- ingress: BFT -> leaf ----------------
  logic                      in_vld;
  logic [DEST_W-1:0]         in_dest;
  logic [NUM_LEAF*PKT_W-1:0] ingress_q;
  logic [15:0]               drop_cnt_q;
  logic [NUM_LEAF-1:0]       leaf_ap_start_q;

  assign in_vld  = bus.din_leaf_bft2interface[PKT_W-1];
  assign in_dest = bus.din_leaf_bft2interface[PKT_W-2 -: DEST_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ingress_q       <= '0;
      drop_cnt_q      <= '0;
      leaf_ap_start_q <= '0;
    end else begin
      ingress_q <= '0;
      for (int i = 0; i < NUM_LEAF; i++) begin
        if (in_vld && in_dest == DEST_W'(i))
          ingress_q[i*PKT_W +: PKT_W] <= bus.din_leaf_bft2interface;
      end
      if (in_vld && ({1'b0, in_dest} >= (DEST_W+1)'(NUM_LEAF)) && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
      leaf_ap_start_q <= {NUM_LEAF{bus.ap_start}};
    end
  end

  // ---------------- egress FIFOs ----------------
  logic [NUM_LEAF-1:0] push, pop, empty, full, drop;
  logic [PKT_W-1:0]    head [NUM_LEAF];
  logic [NUM_LEAF-1:0] overflow_q;

  for (genvar g = 0; g < NUM_LEAF; g++) begin : g_leaf
    assign push[g] = bus.din_leaf_interface2bft[g*PKT_W + PKT_W - 1];
    leaf_pkt_fifo #(.PKT_W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[g]),
      .push_dat (bus.din_leaf_interface2bft[g*PKT_W +: PKT_W]),
      .pop      (pop[g]),
      .head_dat (head[g]),
      .empty    (empty[g]),
      .full     (full[g]),
      .drop     (drop[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= '0;
    else       overflow_q <= overflow_q | drop;
  end

  // ---------------- round-robin arbiter ----------------
  arb_state_t            state;
  logic [PKT_W-1:0]      dout_q;
  logic [IDX_W-1:0]      ptr;
  logic                  stall;
  logic                  gnt_vld;
  logic [IDX_W-1:0]      gnt_idx;
  logic [2*NUM_LEAF-1:0] ne_rot;
  int                    gnt_off;
  int                    gnt_sum;

  // resend only matters when there is actually a packet on dout.
  assign stall = (state != ST_IDLE) && bus.resend && dout_q[PKT_W-1];

  always_comb begin
    // Doubled non-empty vector rotated so bit 0 is leaf ptr+1.
    ne_rot  = {~empty, ~empty} >> (int'(ptr) + 1);
    gnt_vld = 1'b0;
    gnt_off = 0;
    for (int j = NUM_LEAF - 1; j >= 0; j--) begin
      if (ne_rot[j]) begin
        gnt_vld = 1'b1;
        gnt_off = j;
      end
    end
    gnt_sum = int'(ptr) + 1 + gnt_off;
    if (gnt_sum >= NUM_LEAF) gnt_sum = gnt_sum - NUM_LEAF;
    gnt_idx = IDX_W'(gnt_sum);
    pop = '0;
    if (state != ST_IDLE && !stall && gnt_vld)
      pop = NUM_LEAF'(1) << gnt_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      dout_q <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dout_q <= '0;
          if (bus.ap_start) state <= ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          if (stall) begin
            state <= ST_HOLD;
          end else begin
            state <= ST_RUN;
            if (gnt_vld) begin
              dout_q <= head[gnt_idx];
              ptr    <= gnt_idx;
            end else begin
              dout_q <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.dout_leaf_bft2interface = ingress_q;
  assign bus.leaf_ap_start           = leaf_ap_start_q;
  assign bus.overflow                = overflow_q;
  assign bus.drop_cnt                = drop_cnt_q;
endmodule

// File: tb/tb_leaf_multi_arb.sv
// Self-checking bench for leaf_multi_arb: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: resend driven by directed scenarios and randomly.
module tb_leaf_multi_arb;
  localparam int NL    = 2;
  localparam int PW    = 49;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_multi_arb_if #(.NUM_LEAF(NL), .PKT_W(PW)) bus ();

  leaf_multi_arb #(.NUM_LEAF(NL), .PKT_W(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [PW-1:0]    mq [NL][$];
  int               m_ptr;
  int               m_state;   // 0 idle, 1 run, 2 hold
  logic [PW-1:0]    m_dout;
  logic [NL*PW-1:0] m_slices;
  logic [NL-1:0]    m_las;
  logic [NL-1:0]    m_ovf;
  int               m_drop;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mq[i].delete();
    m_ptr = 0; m_state = 0; m_dout = '0; m_slices = '0;
    m_las = '0; m_ovf = '0; m_drop = 0;
  endtask

  // Applies one clock of the behavioural rules using the inputs present at the edge.
  task automatic model_update();
    logic [PW-1:0] din;
    int dest, idx;
    bit found;
    din = bus.din_leaf_bft2interface;
    m_slices = '0;
    if (din[PW-1]) begin
      dest = int'(din[PW-2 -: 4]);
      if (dest < NL) m_slices[dest*PW +: PW] = din;
      else if (m_drop < 65535) m_drop++;
    end
    m_las = {NL{bus.ap_start}};
    if (m_state == 0) begin
      m_dout = '0;
      if (bus.ap_start) m_state = 1;
    end else if (bus.resend && m_dout[PW-1]) begin
      m_state = 2;
    end else begin
      m_state = 1;
      found = 0;
      for (int k = 1; k <= NL; k++) begin
        idx = (m_ptr + k) % NL;
        if (!found && mq[idx].size() > 0) begin
          found = 1;
          m_dout = mq[idx].pop_front();
          m_ptr = idx;
        end
      end
      if (!found) m_dout = '0;
    end
    for (int i = 0; i < NL; i++) begin
      if (bus.din_leaf_interface2bft[i*PW + PW - 1]) begin
        if (mq[i].size() >= DEPTH) m_ovf[i] = 1'b1;
        else mq[i].push_back(bus.din_leaf_interface2bft[i*PW +: PW]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [PW-1:0] mkpkt(input int dest, input logic [43:0] pay);
    logic [3:0] d;
    d = dest[3:0];
    return {1'b1, d, pay};
  endfunction

  task automatic drive_idle();
    bus.din_leaf_bft2interface = '0;
    bus.din_leaf_interface2bft = '0;
    bus.resend   = 1'b0;
    bus.ap_start = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus.dout_leaf_interface2bft !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", bus.dout_leaf_interface2bft); end
    n_cmp++; if (bus.dout_leaf_bft2interface !== '0) begin n_err++; $display("FAIL reset_slices: got %h want 0", bus.dout_leaf_bft2interface); end
    n_cmp++; if (bus.leaf_ap_start !== '0) begin n_err++; $display("FAIL reset_las: got %b want 0", bus.leaf_ap_start); end
    n_cmp++; if (bus.overflow !== '0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
  endtask

  task automatic test_ingress();
    logic [PW-1:0] pkt;
    logic [NL*PW-1:0] exp;
    apply_reset();
    pkt = mkpkt(1, 44'h0_0000_0000_AB);
    bus.din_leaf_bft2interface = pkt;
    bus.ap_start = 1'b1;
    step();
    bus.din_leaf_bft2interface = '0;
    exp = '0; exp[1*PW +: PW] = pkt;
    n_cmp++; if (bus.dout_leaf_bft2interface !== exp) begin n_err++; $display("FAIL ingress_route: got %h want %h", bus.dout_leaf_bft2interface, exp); end
    n_cmp++; if (bus.leaf_ap_start !== 2'b11) begin n_err++; $display("FAIL las_rise: got %b want 11", bus.leaf_ap_start); end
    bus.din_leaf_bft2interface = pkt & ~(PW'(1) << (PW-1));   // valid bit cleared
    bus.ap_start = 1'b0;
    step();
    n_cmp++; if (bus.dout_leaf_bft2interface !== '0) begin n_err++; $display("FAIL ingress_oneshot: got %h want 0", bus.dout_leaf_bft2interface); end
    step();
    n_cmp++; if (bus.dout_leaf_bft2interface !== '0) begin n_err++; $display("FAIL ingress_novalid: got %h want 0", bus.dout_leaf_bft2interface); end
    n_cmp++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL ingress_novalid_drop: got %0d want 0", bus.drop_cnt); end
    n_cmp++; if (bus.leaf_ap_start !== 2'b00) begin n_err++; $display("FAIL las_fall: got %b want 00", bus.leaf_ap_start); end
    bus.din_leaf_bft2interface = '0;
  endtask

  task automatic test_invalid_dest();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      bus.din_leaf_bft2interface = mkpkt(5, 44'(k + 16));
      step();
      n_cmp++; if (bus.dout_leaf_bft2interface !== '0) begin n_err++; $display("FAIL baddest_slices: got %h want 0", bus.dout_leaf_bft2interface); end
    end
    bus.din_leaf_bft2interface = '0;
    step();
    n_cmp++; if (bus.drop_cnt !== 16'd3) begin n_err++; $display("FAIL baddest_cnt: got %0d want 3", bus.drop_cnt); end
  endtask

  task automatic test_round_robin();
    logic [PW-1:0] got [$];
    int first, last, bad;
    apply_reset();
    first = -1; last = -1; bad = 0;
    bus.ap_start = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NL; i++)
        bus.din_leaf_interface2bft[i*PW +: PW] = (c < 4) ? mkpkt(0, 44'(i*256 + c)) : '0;
      step();
      n_cmp++; if (bus.dout_leaf_interface2bft !== m_dout) begin n_err++; $display("FAIL rr_dout c=%0d: got %h want %h", c, bus.dout_leaf_interface2bft, m_dout); end
      if (bus.dout_leaf_interface2bft[PW-1]) begin
        got.push_back(bus.dout_leaf_interface2bft);
        if (first < 0) first = c;
        last = c;
      end
    end
    n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL rr_count: got %0d want 8", got.size()); end
    n_cmp++; if (last - first + 1 != 8) begin n_err++; $display("FAIL rr_gapless: span %0d want 8", last - first + 1); end
    for (int k = 1; k < got.size(); k++) if (got[k][8] === got[k-1][8]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rr_alternate: got %0d repeats want 0", bad); end
  endtask

  task automatic test_resend_hold();
    logic [PW-1:0] p [3];
    apply_reset();
    for (int k = 0; k < 3; k++) p[k] = mkpkt(0, 44'(32'hA000 + k));
    bus.ap_start = 1'b1;
    step();
    bus.resend = 1'b1;                 // dout invalid: must be ignored
    step(); step();
    n_cmp++; if (bus.dout_leaf_interface2bft !== '0) begin n_err++; $display("FAIL resend_idle: got %h want 0", bus.dout_leaf_interface2bft); end
    bus.resend = 1'b0;
    bus.ap_start = 1'b0;               // dropping ap_start must not stop the arbiter
    bus.din_leaf_interface2bft[0 +: PW] = p[0];
    step();
    bus.din_leaf_interface2bft[0 +: PW] = p[1];
    step();
    n_cmp++; if (bus.dout_leaf_interface2bft !== p[0]) begin n_err++; $display("FAIL hold_first: got %h want %h", bus.dout_leaf_interface2bft, p[0]); end
    bus.din_leaf_interface2bft[0 +: PW] = p[2];
    bus.resend = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.din_leaf_interface2bft = '0;
      n_cmp++; if (bus.dout_leaf_interface2bft !== p[0]) begin n_err++; $display("FAIL hold_keep k=%0d: got %h want %h", k, bus.dout_leaf_interface2bft, p[0]); end
    end
    bus.resend = 1'b0;
    step();
    n_cmp++; if (bus.dout_leaf_interface2bft !== p[1]) begin n_err++; $display("FAIL hold_next: got %h want %h", bus.dout_leaf_interface2bft, p[1]); end
    step();
    n_cmp++; if (bus.dout_leaf_interface2bft !== p[2]) begin n_err++; $display("FAIL hold_third: got %h want %h", bus.dout_leaf_interface2bft, p[2]); end
    step();
    n_cmp++; if (bus.dout_leaf_interface2bft !== '0) begin n_err++; $display("FAIL hold_drain: got %h want 0", bus.dout_leaf_interface2bft); end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] p [5];
    logic [PW-1:0] got [$];
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      p[k] = mkpkt(0, 44'(32'hB000 + k));
      bus.din_leaf_interface2bft[0 +: PW] = p[k];
      step();
    end
    bus.din_leaf_interface2bft = '0;
    n_cmp++; if (bus.overflow !== 2'b01) begin n_err++; $display("FAIL ovf_flag: got %b want 01", bus.overflow); end
    n_cmp++; if (bus.dout_leaf_interface2bft !== '0) begin n_err++; $display("FAIL ovf_idle_dout: got %h want 0", bus.dout_leaf_interface2bft); end
    bus.ap_start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.dout_leaf_interface2bft[PW-1]) got.push_back(bus.dout_leaf_interface2bft);
    end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_cmp++; if (got[k] !== p[k]) begin n_err++; $display("FAIL ovf_order k=%0d: got %h want %h", k, got[k], p[k]); end
    end
    n_cmp++; if (bus.overflow !== 2'b01) begin n_err++; $display("FAIL ovf_sticky: got %b want 01", bus.overflow); end
  endtask

  task automatic test_reset_mid_hold();
    logic [PW-1:0] pn;
    int waited;
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NL; i++) bus.din_leaf_interface2bft[i*PW +: PW] = mkpkt(0, 44'(32'hC000 + i*16 + c));
      bus.din_leaf_bft2interface = mkpkt(7, 44'h5);
      step();
    end
    bus.din_leaf_interface2bft = '0;
    bus.din_leaf_bft2interface = mkpkt(0, 44'h77);
    bus.ap_start = 1'b1;
    step(); step();
    n_cmp++; if (bus.dout_leaf_interface2bft[PW-1] !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", bus.dout_leaf_interface2bft[PW-1]); end
    bus.resend = 1'b1;
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.dout_leaf_interface2bft !== '0) begin n_err++; $display("FAIL mid_rst_dout: got %h want 0", bus.dout_leaf_interface2bft); end
    n_cmp++; if (bus.dout_leaf_bft2interface !== '0) begin n_err++; $display("FAIL mid_rst_slices: got %h want 0", bus.dout_leaf_bft2interface); end
    n_cmp++; if (bus.leaf_ap_start !== '0) begin n_err++; $display("FAIL mid_rst_las: got %b want 0", bus.leaf_ap_start); end
    n_cmp++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_drop: got %0d want 0", bus.drop_cnt); end
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (bus.dout_leaf_interface2bft !== '0) begin n_err++; $display("FAIL mid_post_quiet c=%0d: got %h want 0", c, bus.dout_leaf_interface2bft); end
    end
    pn = mkpkt(0, 44'hD00D);
    bus.din_leaf_interface2bft[0 +: PW] = pn;
    bus.ap_start = 1'b1;
    step();
    bus.din_leaf_interface2bft = '0;
    waited = 0;
    while (!bus.dout_leaf_interface2bft[PW-1] && waited < 10) begin step(); waited++; end
    n_cmp++; if (bus.dout_leaf_interface2bft !== pn) begin n_err++; $display("FAIL mid_post_new: got %h want %h", bus.dout_leaf_interface2bft, pn); end
  endtask

  task automatic test_random();
    logic [PW-1:0] pkt;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      bus.ap_start = ($urandom_range(0, 9) != 0);
      bus.resend   = ($urandom_range(0, 9) < 3);
      pkt = mkpkt($urandom_range(0, 15), 44'({$urandom(), $urandom()}));
      if ($urandom_range(0, 1) == 0) pkt[PW-1] = 1'b0;
      bus.din_leaf_bft2interface = pkt;
      for (int i = 0; i < NL; i++) begin
        pkt = mkpkt($urandom_range(0, 15), 44'({$urandom(), $urandom()}));
        if ($urandom_range(0, 9) >= 4) pkt[PW-1] = 1'b0;
        bus.din_leaf_interface2bft[i*PW +: PW] = pkt;
      end
      step();
      n_cmp++; if (bus.dout_leaf_interface2bft !== m_dout) begin n_err++; $display("FAIL rnd_dout c=%0d: got %h want %h", c, bus.dout_leaf_interface2bft, m_dout); end
      n_cmp++; if (bus.dout_leaf_bft2interface !== m_slices) begin n_err++; $display("FAIL rnd_slices c=%0d: got %h want %h", c, bus.dout_leaf_bft2interface, m_slices); end
      n_cmp++; if (bus.leaf_ap_start !== m_las) begin n_err++; $display("FAIL rnd_las c=%0d: got %b want %b", c, bus.leaf_ap_start, m_las); end
      n_cmp++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, bus.overflow, m_ovf); end
      n_cmp++; if (bus.drop_cnt !== 16'(m_drop)) begin n_err++; $display("FAIL rnd_drop c=%0d: got %0d want %0d", c, bus.drop_cnt, m_drop); end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_ingress();
    test_invalid_dest();
    test_round_robin();
    test_resend_hold();
    test_overflow();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
